// File: rtl/parking_occupancy_ctrl.sv
// Parking-lot occupancy counter: edge-detected entry/exit requests, saturating
// vehicle count, barrier-gate hold timer, full/empty flags and a two-digit BCD display.
module parking_occupancy_ctrl #(
   parameter int CAPACITY    = 16,
   parameter int CNT_W       = 7,
   parameter int GATE_CYCLES = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             entering,
   input  logic             exiting,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty,
   output logic             gate_open,
   output logic             reject,
   output logic [3:0]       bcd_tens,
   output logic [3:0]       bcd_ones
);

   // state | meaning
   // IDLE  | gate closed, no accepted event pending
   // OPEN  | gate held open, timer counting down to close
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] OPEN = 1'b1;

   localparam logic [CNT_W-1:0] CAP_C   = CNT_W'(CAPACITY);
   localparam logic [7:0]       RELOAD_C = 8'(GATE_CYCLES - 1);

   logic             ent_hist_q, ext_hist_q;
   logic [CNT_W-1:0] count_q, count_d;
   logic             reject_q, reject_d;
   logic [0:0]       state_q, state_d;
   logic [7:0]       timer_q, timer_d;

   logic ent_ev, ext_ev, ent_acc, ext_acc, any_acc;

   assign ent_ev  = entering & ~ent_hist_q;
   assign ext_ev  = exiting  & ~ext_hist_q;
   assign ext_acc = ext_ev & (count_q != '0);
   // A simultaneous accepted exit frees the slot, so a full lot can still admit.
   assign ent_acc = ent_ev & ((count_q < CAP_C) | ext_acc);
   assign any_acc = ent_acc | ext_acc;

   always_comb begin
      count_d  = count_q;
      reject_d = ent_ev & ~ent_acc;
      if (ent_acc && !ext_acc)
         count_d = count_q + 1'b1;
      else if (ext_acc && !ent_acc)
         count_d = count_q - 1'b1;
   end

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      case (state_q)
         IDLE: begin
            if (any_acc) begin
               state_d = OPEN;
               timer_d = RELOAD_C;
            end
         end
         OPEN: begin
            if (any_acc)
               timer_d = RELOAD_C;
            else if (timer_q == 8'd0)
               state_d = IDLE;
            else
               timer_d = timer_q - 8'd1;
         end
         default: begin
            state_d = IDLE;
            timer_d = 8'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ent_hist_q <= 1'b0;
         ext_hist_q <= 1'b0;
         count_q    <= '0;
         reject_q   <= 1'b0;
         state_q    <= IDLE;
         timer_q    <= 8'd0;
      end else begin
         ent_hist_q <= entering;
         ext_hist_q <= exiting;
         count_q    <= count_d;
         reject_q   <= reject_d;
         state_q    <= state_d;
         timer_q    <= timer_d;
      end
   end

   assign count     = count_q;
   assign reject    = reject_q;
   assign gate_open = (state_q == OPEN);
   assign full      = (count_q == CAP_C);
   assign empty     = (count_q == '0);
   assign bcd_tens  = 4'(count_q / CNT_W'(10));
   assign bcd_ones  = 4'(count_q % CNT_W'(10));

endmodule

// File: tb/tb_parking_occupancy_ctrl.sv
// Randomized and directed bench for parking_occupancy_ctrl against an
// arithmetic occupancy/gate model.
module tb_parking_occupancy_ctrl;

   localparam int CAPACITY    = 16;
   localparam int CNT_W       = 7;
   localparam int GATE_CYCLES = 8;

   logic             clk = 1'b0;
   logic             reset;
   logic             entering, exiting;
   logic [CNT_W-1:0] count;
   logic             full, empty, gate_open, reject;
   logic [3:0]       bcd_tens, bcd_ones;

   int total = 0;
   int bad   = 0;

   // reference model state
   int m_cnt, m_rem;
   bit m_rej, m_pe, m_px;

   parking_occupancy_ctrl #(
      .CAPACITY(CAPACITY), .CNT_W(CNT_W), .GATE_CYCLES(GATE_CYCLES)
   ) dut (
      .clk(clk), .reset(reset), .entering(entering), .exiting(exiting),
      .count(count), .full(full), .empty(empty), .gate_open(gate_open),
      .reject(reject), .bcd_tens(bcd_tens), .bcd_ones(bcd_ones)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      if (obs != exp) begin
         bad++;
         $display("FAIL %s: got %0d, want %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_cnt = 0; m_rem = 0; m_rej = 0; m_pe = 0; m_px = 0;
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".count"}, int'(count), m_cnt);
      chk({tag, ".full"}, int'(full), int'(m_cnt == CAPACITY));
      chk({tag, ".empty"}, int'(empty), int'(m_cnt == 0));
      chk({tag, ".gate"}, int'(gate_open), int'(m_rem > 0));
      chk({tag, ".reject"}, int'(reject), int'(m_rej));
      chk({tag, ".tens"}, int'(bcd_tens), m_cnt / 10);
      chk({tag, ".ones"}, int'(bcd_ones), m_cnt % 10);
   endtask

   // One clock: drive at the falling edge, predict, check 1 ns after the rising edge.
   task automatic step(input bit e, input bit x, input string tag);
      bit e_ev, x_ev, e_acc, x_acc;
      @(negedge clk);
      entering = e;
      exiting  = x;
      reset    = 1'b1;
      e_ev  = e && !m_pe;
      x_ev  = x && !m_px;
      x_acc = x_ev && (m_cnt > 0);
      e_acc = e_ev && ((m_cnt < CAPACITY) || x_acc);
      m_rej = e_ev && !e_acc;
      m_cnt = m_cnt + int'(e_acc) - int'(x_acc);
      if (e_acc || x_acc) m_rem = GATE_CYCLES;
      else if (m_rem > 0) m_rem--;
      m_pe = e;
      m_px = x;
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic pulse(input bit e, input bit x, input string tag);
      step(e, x, tag);
      step(e, x, tag);
      step(0, 0, tag);
   endtask

   task automatic idle(input int n, input string tag);
      for (int i = 0; i < n; i++) step(0, 0, tag);
   endtask

   initial begin
      reset = 1'b0; entering = 1'b0; exiting = 1'b0;
      model_reset();
      #12;
      check_all("reset");

      // three entries, then watch the gate close
      for (int i = 0; i < 3; i++) pulse(1, 0, "three_in");
      chk("three_in.tens_const", int'(bcd_tens), 0);
      chk("three_in.ones_const", int'(bcd_ones), 3);
      idle(10, "gate_close");

      // held level counts once
      for (int i = 0; i < 20; i++) step(1, 0, "hold");
      step(0, 0, "hold");
      chk("hold.count_const", int'(count), 4);
      idle(10, "hold_idle");

      // fill to capacity then try one more
      while (m_cnt < CAPACITY) pulse(1, 0, "fill");
      idle(10, "fill_idle");
      chk("fill.full_const", int'(full), 1);
      chk("fill.tens_const", int'(bcd_tens), 1);
      chk("fill.ones_const", int'(bcd_ones), 6);
      step(1, 0, "over");
      chk("over.reject_const", int'(reject), 1);
      chk("over.gate_const", int'(gate_open), 0);
      step(1, 0, "over2");
      chk("over2.reject_const", int'(reject), 0);
      step(0, 0, "over3");

      // simultaneous at full
      step(1, 1, "both_full");
      chk("both_full.count_const", int'(count), 16);
      chk("both_full.gate_const", int'(gate_open), 1);
      step(0, 0, "both_full");
      idle(10, "both_full_idle");

      // drain to empty, then exit at zero and simultaneous at zero
      while (m_cnt > 0) pulse(0, 1, "drain");
      idle(10, "drain_idle");
      pulse(0, 1, "exit_at_zero");
      chk("exit_at_zero.count_const", int'(count), 0);
      idle(3, "exit_at_zero_idle");
      step(1, 1, "both_zero");
      chk("both_zero.count_const", int'(count), 1);
      step(0, 0, "both_zero");
      idle(10, "both_zero_idle");

      // retriggered gate: entries 2 cycles apart
      for (int i = 0; i < 4; i++) begin
         step(1, 0, "retrig");
         step(0, 0, "retrig");
      end
      idle(10, "retrig_idle");

      // async reset mid-operation
      while (m_cnt < 5) pulse(1, 0, "to5");
      step(1, 0, "to5_open");
      step(0, 0, "to5_open");
      #3;
      reset = 1'b0;
      #1;
      model_reset();
      chk("async.count", int'(count), 0);
      chk("async.gate", int'(gate_open), 0);
      chk("async.empty", int'(empty), 1);
      entering = 1'b1;
      step(1, 0, "release_high");
      chk("release_high.count_const", int'(count), 1);
      step(0, 0, "release_low");

      // randomized traffic with changing entry/exit bias
      for (int blk = 0; blk < 12; blk++) begin
         int pe, px;
         pe = $urandom_range(10, 90);
         px = $urandom_range(10, 90);
         for (int i = 0; i < 150; i++)
            step(($urandom_range(0, 99) < pe), ($urandom_range(0, 99) < px), "rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
